// File: rtl/seven_segment_scan_controller_if.sv
// Load port between the value producer and the scan controller.
// Producer (master) offers data/decimal points; controller (slave) answers with ready.
interface seven_segment_scan_controller_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;

  modport master (output load_valid, output load_data, output load_dp, input load_ready);
  modport slave  (input load_valid, input load_data, input load_dp, output load_ready);
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Scans a 4-digit common-cathode display: dead-time, rotating active-low select, hex decode.
// Outputs registered (same edge as state change); load_ready low while a shadow value waits for frame end.
module seven_segment_scan_controller #(
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 lz_blank,
  seven_segment_scan_controller_if.slave       load_if,
  output logic [3:0]                           select,
  output logic [6:0]                           segments,
  output logic                                 dp,
  output logic                                 frame_done
);

  localparam int CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] SLOT_LAST  = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_ptr, w_ptr_nxt;
  logic [15:0]   r_active, r_shadow, w_active_nxt;
  logic [3:0]    r_active_dp, r_shadow_dp, w_active_dp_nxt;
  logic          r_full;
  logic [3:0]    r_select;
  logic [6:0]    r_segments;
  logic          r_dp;
  logic          r_frame_done;
  logic          w_accept;
  logic          w_promote;
  logic          w_drive_nxt;
  logic [3:0]    w_nib;
  logic [6:0]    w_glyph;
  logic [3:0]    w_dark;

  assign load_if.load_ready = ~r_full;
  assign w_accept   = load_if.load_valid & ~r_full;
  // Promotion only when something is pending; an accept in the frame_done cycle waits a frame.
  assign w_promote  = r_frame_done & r_full;

  assign select     = r_select;
  assign segments   = r_segments;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ptr   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    if (!enable) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
      w_ptr_nxt   = 2'd3;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = HAS_BLANK ? BLANK : DRIVE;
          w_cnt_nxt   = '0;
          w_ptr_nxt   = 2'd3;
        end
        BLANK: begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == BLANK_LAST) w_state_nxt = DRIVE;
        end
        DRIVE: begin
          if (r_cnt == SLOT_LAST) begin
            w_cnt_nxt   = '0;
            w_ptr_nxt   = r_ptr - 1'b1;
            w_state_nxt = HAS_BLANK ? BLANK : DRIVE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Decode from the value that will be active after this edge so a promotion shows immediately.
  always_comb begin
    w_active_nxt    = w_promote ? r_shadow : r_active;
    w_active_dp_nxt = w_promote ? r_shadow_dp : r_active_dp;
    w_drive_nxt     = (w_state_nxt == DRIVE);
    w_nib           = w_active_nxt[{w_ptr_nxt, 2'b00} +: 4];
    w_dark[3]       = lz_blank & (w_active_nxt[15:12] == 4'h0);
    w_dark[2]       = w_dark[3] & (w_active_nxt[11:8] == 4'h0);
    w_dark[1]       = w_dark[2] & (w_active_nxt[7:4] == 4'h0);
    w_dark[0]       = 1'b0;
    case (w_nib)
      4'h0: w_glyph = 7'h7E;
      4'h1: w_glyph = 7'h30;
      4'h2: w_glyph = 7'h6D;
      4'h3: w_glyph = 7'h79;
      4'h4: w_glyph = 7'h33;
      4'h5: w_glyph = 7'h5B;
      4'h6: w_glyph = 7'h5F;
      4'h7: w_glyph = 7'h70;
      4'h8: w_glyph = 7'h7F;
      4'h9: w_glyph = 7'h7B;
      4'hA: w_glyph = 7'h77;
      4'hB: w_glyph = 7'h1F;
      4'hC: w_glyph = 7'h4E;
      4'hD: w_glyph = 7'h3D;
      4'hE: w_glyph = 7'h4F;
      default: w_glyph = 7'h47;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_active    <= '0;
      r_active_dp <= '0;
      r_shadow    <= '0;
      r_shadow_dp <= '0;
      r_full      <= 1'b0;
    end else if (w_promote) begin
      r_active    <= r_shadow;
      r_active_dp <= r_shadow_dp;
      r_full      <= 1'b0;
    end else if (w_accept) begin
      r_shadow    <= load_if.load_data;
      r_shadow_dp <= load_if.load_dp;
      r_full      <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_select     <= 4'b1111;
      r_segments   <= '0;
      r_dp         <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_select     <= w_drive_nxt ? ~(4'b0001 << w_ptr_nxt) : 4'b1111;
      r_segments   <= (w_drive_nxt && !w_dark[w_ptr_nxt]) ? w_glyph : 7'h00;
      r_dp         <= w_drive_nxt & w_active_dp_nxt[w_ptr_nxt];
      r_frame_done <= w_drive_nxt && (w_ptr_nxt == 2'd0) && (w_cnt_nxt == SLOT_LAST);
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for the scan controller with 8-cycle slots and 2-cycle dead-time.
module tb_seven_segment_scan_controller;

  logic       clock;
  logic       reset_n;
  logic       enable;
  logic       lz_blank;
  logic [3:0] select;
  logic [6:0] segments;
  logic       dp;
  logic       frame_done;

  seven_segment_scan_controller_if lif();

  seven_segment_scan_controller #(.SLOT_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .lz_blank(lz_blank),
    .load_if(lif), .select(select), .segments(segments), .dp(dp), .frame_done(frame_done)
  );

  typedef struct {
    logic        lz;
    logic [15:0] data;
    logic [3:0]  dpi;
    logic [6:0]  s3, s2, s1, s0;
    logic [3:0]  dpo;
  } vec_t;

  vec_t       tbl [8];
  int         checks = 0;
  int         failures = 0;
  logic [6:0] cap_seg [4];
  logic [3:0] cap_dp;
  int         cap_n [4];
  int         cap_blank;
  int         cap_dark_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_fd();
    int n = 0;
    while (frame_done !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    chk("fd_wait", frame_done, 1);
  endtask

  task automatic wait_sel(input logic [3:0] s);
    int n = 0;
    while (select !== s && n < 100) begin @(negedge clock); n++; end
    chk("sel_wait", select, s);
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p);
    int n = 0;
    lif.load_data  = d;
    lif.load_dp    = p;
    lif.load_valid = 1'b1;
    while (lif.load_ready !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    chk("ready_wait", lif.load_ready, 1);
    @(negedge clock);
    lif.load_valid = 1'b0;
  endtask

  // Records one full frame period of samples, sorted by which digit is selected.
  task automatic capture();
    for (int d = 0; d < 4; d++) begin cap_n[d] = 0; cap_seg[d] = 7'h00; end
    cap_dp = 4'b0000; cap_blank = 0; cap_dark_err = 0;
    for (int i = 0; i < 32; i++) begin
      case (select)
        4'b0111: begin cap_seg[3] = segments; cap_dp[3] = dp; cap_n[3]++; end
        4'b1011: begin cap_seg[2] = segments; cap_dp[2] = dp; cap_n[2]++; end
        4'b1101: begin cap_seg[1] = segments; cap_dp[1] = dp; cap_n[1]++; end
        4'b1110: begin cap_seg[0] = segments; cap_dp[0] = dp; cap_n[0]++; end
        4'b1111: begin cap_blank++; if (segments !== 7'h00 || dp !== 1'b0) cap_dark_err++; end
        default: cap_dark_err++;
      endcase
      @(negedge clock);
    end
  endtask

  task automatic check_frame(input string nm, input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] dpo);
    chk({nm, "_d3"}, cap_seg[3], s3);
    chk({nm, "_d2"}, cap_seg[2], s2);
    chk({nm, "_d1"}, cap_seg[1], s1);
    chk({nm, "_d0"}, cap_seg[0], s0);
    chk({nm, "_dp"}, cap_dp, dpo);
    chk({nm, "_slots"}, {8'(cap_n[3]), 8'(cap_n[2]), 8'(cap_n[1]), 8'(cap_n[0])}, 32'h06060606);
    chk({nm, "_blank"}, cap_blank, 8);
    chk({nm, "_dark"}, cap_dark_err, 0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 16'h1234, 4'b0000, 7'h30, 7'h6D, 7'h79, 7'h33, 4'b0000};
    tbl[1] = '{1'b0, 16'h89AB, 4'b0001, 7'h7F, 7'h7B, 7'h77, 7'h1F, 4'b0001};
    tbl[2] = '{1'b0, 16'hCDEF, 4'b1010, 7'h4E, 7'h3D, 7'h4F, 7'h47, 4'b1010};
    tbl[3] = '{1'b1, 16'h0070, 4'b0000, 7'h00, 7'h00, 7'h70, 7'h7E, 4'b0000};
    tbl[4] = '{1'b1, 16'h0000, 4'b0000, 7'h00, 7'h00, 7'h00, 7'h7E, 4'b0000};
    tbl[5] = '{1'b0, 16'h0000, 4'b1111, 7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b1111};
    tbl[6] = '{1'b1, 16'h0506, 4'b0100, 7'h00, 7'h5B, 7'h7E, 7'h5F, 4'b0100};
    tbl[7] = '{1'b1, 16'h0001, 4'b1000, 7'h00, 7'h00, 7'h00, 7'h30, 4'b1000};

    reset_n = 1'b0; enable = 1'b0; lz_blank = 1'b0;
    lif.load_valid = 1'b0; lif.load_data = '0; lif.load_dp = '0;
    #12;
    chk("rst_select", select, 4'b1111);
    chk("rst_segments", segments, 0);
    chk("rst_dp", dp, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_ready", lif.load_ready, 1);
    @(negedge clock); reset_n = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_select", select, 4'b1111);

    // Exact select / frame_done timing over two frames from enable.
    enable = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      int slot, pos;
      logic [3:0] es;
      @(negedge clock);
      slot = (k - 1) / 8;
      pos  = (k - 1) % 8;
      es   = (pos < 2) ? 4'b1111 : ~(4'b0001 << (3 - (slot % 4)));
      chk("scan_sel", select, es);
      chk("scan_fd", frame_done, (pos == 7 && (slot % 4) == 3) ? 1 : 0);
    end

    for (int t = 0; t < 8; t++) begin
      lz_blank = tbl[t].lz;
      do_load(tbl[t].data, tbl[t].dpi);
      wait_fd();
      @(negedge clock);
      capture();
      check_frame($sformatf("vec%0d", t), tbl[t].s3, tbl[t].s2, tbl[t].s1, tbl[t].s0, tbl[t].dpo);
    end
    lz_blank = 1'b0;

    // Held valid with A then B: one accept per frame.
    begin
      int bad = 0, n = 0;
      lif.load_valid = 1'b1; lif.load_data = 16'hA5C3; lif.load_dp = 4'b0000;
      chk("hs_ready_init", lif.load_ready, 1);
      @(negedge clock);
      lif.load_data = 16'h2468;
      while (frame_done !== 1'b1 && n < 100) begin
        if (lif.load_ready !== 1'b0) bad++;
        @(negedge clock); n++;
      end
      chk("hs_fd_seen", frame_done, 1);
      chk("hs_ready_low_cycles", bad, 0);
      chk("hs_ready_at_fd", lif.load_ready, 0);
      @(negedge clock);
      chk("hs_ready_after_promote", lif.load_ready, 1);
      @(negedge clock);
      chk("hs_b_taken", lif.load_ready, 0);
      lif.load_valid = 1'b0;
      capture();
      check_frame("hs_a", 7'h77, 7'h5B, 7'h4E, 7'h79, 4'b0000);
      wait_fd();
      @(negedge clock);
      capture();
      check_frame("hs_b", 7'h6D, 7'h33, 7'h5F, 7'h7F, 4'b0000);
    end

    // Offer exactly in the frame_done cycle: old value stays one more frame.
    wait_fd();
    lif.load_valid = 1'b1; lif.load_data = 16'h9F0E; lif.load_dp = 4'b0000;
    chk("fdacc_ready", lif.load_ready, 1);
    @(negedge clock);
    chk("fdacc_taken", lif.load_ready, 0);
    lif.load_valid = 1'b0;
    capture();
    check_frame("fdacc_old", 7'h6D, 7'h33, 7'h5F, 7'h7F, 4'b0000);
    wait_fd();
    @(negedge clock);
    capture();
    check_frame("fdacc_new", 7'h7B, 7'h47, 7'h7E, 7'h4F, 4'b0000);

    // Disable during digit 1 with a pending load, then resume.
    do_load(16'h3B7D, 4'b0000);
    wait_sel(4'b1101);
    enable = 1'b0;
    @(negedge clock);
    chk("dis_select", select, 4'b1111);
    chk("dis_segments", segments, 0);
    chk("dis_dp", dp, 0);
    repeat (4) @(negedge clock);
    chk("dis_hold_select", select, 4'b1111);
    chk("dis_shadow_kept", lif.load_ready, 0);
    chk("dis_fd", frame_done, 0);
    enable = 1'b1;
    @(negedge clock); chk("res_k1", select, 4'b1111);
    @(negedge clock); chk("res_k2", select, 4'b1111);
    @(negedge clock); chk("res_k3", select, 4'b0111);
    chk("res_old_value", segments, 7'h7B);
    wait_fd();
    @(negedge clock);
    capture();
    check_frame("res_new", 7'h79, 7'h1F, 7'h70, 7'h3D, 4'b0000);

    // Asynchronous reset mid-DRIVE with a pending load.
    do_load(16'hFFFF, 4'b1111);
    wait_sel(4'b1011);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_select", select, 4'b1111);
    chk("arst_ready", lif.load_ready, 1);
    chk("arst_segments", segments, 0);
    chk("arst_dp", dp, 0);
    chk("arst_fd", frame_done, 0);
    @(negedge clock);
    reset_n = 1'b1;
    wait_fd();
    @(negedge clock);
    capture();
    check_frame("arst_cleared", 7'h7E, 7'h7E, 7'h7E, 7'h7E, 4'b0000);
    chk("arst_no_pending", lif.load_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
